// File: rtl/cpu_pkg.sv
// Shared types and constants for the core's memory-side logic.
package cpu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // RAM is word addressed; the two byte-offset bits are always forced to zero.
    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serialises instruction fetches and data loads/stores
// from the core onto one RAM port, data taking priority over fetch.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer in flight; samples d_pend / i_req
// FETCH | RAM read at the aligned i_addr, waiting for ram_busy=0
// DATA  | RAM read or write at the aligned d_addr, waiting for ram_busy=0
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] d_rdata,
    output logic              i_ready,
    output logic              d_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_busy
);

    localparam logic [ADDR_W-1:0] ALIGN = WORD_ALIGN_MASK[ADDR_W-1:0];

    arb_state_t state;
    arb_state_t state_nxt;
    logic       d_done;
    logic       d_pend;
    logic       fetch_done;
    logic       data_done;

    // d_done blocks a held memRead/memWrite from being replayed for the same instruction.
    assign d_pend     = (d_ren | d_wen) & ~d_done;
    assign fetch_done = (state == FETCH) & ~ram_busy;
    assign data_done  = (state == DATA) & ~ram_busy;

    // State register; reset also drops the combinational RAM strobes at once.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and RAM port drive; addresses/data track the core combinationally.
    always_comb begin
        state_nxt = state;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                if (d_pend) begin
                    state_nxt = DATA;
                end else if (i_req) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                ram_ren  = 1'b1;
                ram_addr = i_addr & ALIGN;
                if (!ram_busy) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                ram_addr  = d_addr & ALIGN;
                ram_wdata = d_wdata;
                // A store wins when the core asserts both read and write.
                if (d_wen) begin
                    ram_wen = 1'b1;
                end else begin
                    ram_ren = 1'b1;
                end
                if (!ram_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion capture: returned words, one-cycle ready pulses and the replay guard.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            instruction <= '0;
            d_rdata     <= '0;
            i_ready     <= 1'b0;
            d_ready     <= 1'b0;
            d_done      <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (fetch_done) begin
                instruction <= ram_rdata;
                i_ready     <= 1'b1;
            end
            if (data_done) begin
                if (!d_wen) begin
                    d_rdata <= ram_rdata;
                end
                d_ready <= 1'b1;
                d_done  <= 1'b1;
            end else if ((!d_ren && !d_wen) || i_ready) begin
                d_done <= 1'b0;
            end
        end
    end

endmodule
